// File: rtl/uart_tx_core.sv
// uart_tx_core: bit-serial UART transmitter, LSB-first with start bit,
// optional parity bit and one or two stop bits, one bit per tick_i.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   tick_i                bit-period strobe, one clk_i cycle wide
//   data_i/valid_i/ready_o  word handshake (transfer on valid_i && ready_o)
//   parity_en_i           append a parity bit
//   parity_odd_i          1 = odd parity, 0 = even parity
//   stop2_i               1 = two stop bits, 0 = one stop bit
//   tx_o                  registered serial line, idle high
//   busy_o                frame in progress
//   done_o                one-cycle pulse when the last stop bit completes
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tick_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
    input  logic                  stop2_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tx_q, tx_d;
    logic                    done_q, done_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic                    stop2_q, stop2_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // A tick coinciding with the transfer is deliberately
                // ignored; ALIGN waits for the next one.
                if (valid_i) begin
                    state_d   = ALIGN;
                    shift_d   = data_i;
                    par_en_d  = parity_en_i;
                    // Parity is fixed at capture since the shifter is
                    // consumed while the data bits go out.
                    par_bit_d = (^data_i) ^ parity_odd_i;
                    stop2_d   = stop2_i;
                end
            end
            ALIGN: begin
                if (tick_i) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (tick_i) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                end
            end
            DATA: begin
                if (tick_i) begin
                    if (cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP1;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    end
                end
            end
            PARITY: begin
                if (tick_i) begin
                    state_d = STOP1;
                    tx_d    = 1'b1;
                end
            end
            STOP1: begin
                if (tick_i) begin
                    tx_d = 1'b1;
                    if (stop2_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (tick_i) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);
    assign tx_o    = tx_q;
    assign done_o  = done_q;

endmodule
